// File: rtl/conv_oc_sched.sv
// Per-output-pixel scheduler: walks output channels 0..OC, sequencing bias load, MAC taps,
// pipeline drain, bias add with int8 saturation and a valid/ready output. Optional macro: RELU_EN.
module conv_oc_sched #(
    parameter int OC      = 7,
    parameter int NK      = 9,
    parameter int MAC_LAT = 2,
    parameter int ACC_W   = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    c_load,
    output logic [3:0]              cout,
    input  logic signed [7:0]       bias,
    output logic                    mac_en,
    output logic                    mac_clr,
    output logic [7:0]              k_idx,
    input  logic signed [ACC_W-1:0] acc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [7:0]       out_data
);

    localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic signed [ACC_W:0] SAT_MAX = 127;
`ifdef RELU_EN
    localparam logic signed [ACC_W:0] SAT_MIN = 0;
`else
    localparam logic signed [ACC_W:0] SAT_MIN = -128;
`endif

    typedef enum logic [2:0] {IDLE, LOAD, MAC, DRAIN, OUT} state_t;

    state_t              state, state_nx;
    logic [DW-1:0]       dcnt;
    logic signed [ACC_W:0] sum;
    logic                last_tap, last_drain, last_ch, hs;

    function automatic logic signed [7:0] sat8(input logic signed [ACC_W:0] s);
        if (s > SAT_MAX)
            return 8'sd127;
        else if (s < SAT_MIN)
            return SAT_MIN[7:0];
        else
            return s[7:0];
    endfunction

    // One extra bit of headroom so acc + bias can never overflow before the clamp.
    assign sum        = $signed({acc[ACC_W-1], acc}) + $signed({{(ACC_W-7){bias[7]}}, bias});
    assign last_tap   = (k_idx == 8'(NK - 1));
    assign last_drain = (dcnt == DW'(MAC_LAT - 1));
    assign last_ch    = (cout == 4'(OC));
    assign hs         = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        c_load   = 1'b0;
        mac_en   = 1'b0;
        mac_clr  = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start)
                    state_nx = LOAD;
            end
            LOAD: begin
                c_load   = 1'b1;
                state_nx = MAC;
            end
            MAC: begin
                mac_en  = 1'b1;
                mac_clr = (k_idx == 8'd0);
                if (last_tap)
                    state_nx = DRAIN;
            end
            DRAIN: begin
                if (last_drain)
                    state_nx = OUT;
            end
            OUT: begin
                if (hs)
                    state_nx = last_ch ? IDLE : LOAD;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cout      <= '0;
            k_idx     <= '0;
            dcnt      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start)
                        cout <= '0;
                end
                LOAD: k_idx <= '0;
                MAC: begin
                    if (last_tap)
                        dcnt <= '0;
                    else
                        k_idx <= k_idx + 8'd1;
                end
                DRAIN: begin
                    if (last_drain) begin
                        out_data  <= sat8(sum);
                        out_valid <= 1'b1;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                OUT: begin
                    if (hs) begin
                        out_valid <= 1'b0;
                        if (last_ch) begin
                            done <= 1'b1;
                            cout <= '0;
                        end else begin
                            cout <= cout + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_oc_sched.sv
// Directed bench for conv_oc_sched: default instance (OC=7, NK=9, MAC_LAT=2) and a
// boundary instance (OC=1, NK=1, MAC_LAT=1) sharing clock and reset.
module tb_conv_oc_sched;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic               start = 1'b0, out_ready = 1'b1;
    logic signed [7:0]  bias = '0;
    logic signed [19:0] acc = '0;
    logic               busy, done, c_load, mac_en, mac_clr, out_valid;
    logic [3:0]         cout;
    logic [7:0]         k_idx;
    logic signed [7:0]  out_data;

    logic               start_b = 1'b0, out_ready_b = 1'b1;
    logic signed [7:0]  bias_b = -8'sd10;
    logic signed [19:0] acc_b = 20'sd50;
    logic               busy_b, done_b, c_load_b, mac_en_b, mac_clr_b, out_valid_b;
    logic [3:0]         cout_b;
    logic [7:0]         k_idx_b;
    logic signed [7:0]  out_data_b;

    conv_oc_sched #(.OC(7), .NK(9), .MAC_LAT(2), .ACC_W(20)) u_a (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .c_load(c_load),
        .cout(cout), .bias(bias), .mac_en(mac_en), .mac_clr(mac_clr), .k_idx(k_idx),
        .acc(acc), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    conv_oc_sched #(.OC(1), .NK(1), .MAC_LAT(1), .ACC_W(20)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .c_load(c_load_b),
        .cout(cout_b), .bias(bias_b), .mac_en(mac_en_b), .mac_clr(mac_clr_b), .k_idx(k_idx_b),
        .acc(acc_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b)
    );

    logic signed [19:0] acc_tab  [8] = '{20'sd100, 20'sd200, -20'sd300, -20'sd5,
                                         20'sd0, 20'sd127, -20'sd128, 20'sd127};
    logic signed [7:0]  bias_tab [8] = '{8'sd20, 8'sd5, -8'sd1, 8'sd10, 8'sd0, 8'sd0, 8'sd0, 8'sd1};
`ifdef RELU_EN
    logic signed [7:0]  exp_tab  [8] = '{8'sd120, 8'sd127, 8'sd0, 8'sd5, 8'sd0, 8'sd127, 8'sd0, 8'sd127};
`else
    logic signed [7:0]  exp_tab  [8] = '{8'sd120, 8'sd127, -8'sd128, 8'sd5, 8'sd0, 8'sd127, -8'sd128, 8'sd127};
`endif

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic test_reset();
        logic [23:0] v;
        rst = 1'b0;
        @(negedge clk);
        v = {busy, done, c_load, cout, mac_en, mac_clr, k_idx, out_valid, out_data[0]};
        checks++;
        if (v !== 24'h0 || out_data !== 8'sd0) begin
            errors++; $display("FAIL reset_a outputs=%h data=%0d want 0", v, out_data);
        end
        v = {busy_b, done_b, c_load_b, cout_b, mac_en_b, mac_clr_b, k_idx_b, out_valid_b, out_data_b[0]};
        checks++;
        if (v !== 24'h0 || out_data_b !== 8'sd0) begin
            errors++; $display("FAIL reset_b outputs=%h data=%0d want 0", v, out_data_b);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_nominal();
        int n_load = 0, n_mac = 0, n_clr = 0, n_val = 0, n_done = 0, done_at = -1, kexp = 0, bad_k = 0;
        out_ready = 1'b1;
        pulse_start();
        checks++;
        if (busy !== 1'b1 || c_load !== 1'b1) begin
            errors++; $display("FAIL nom_first busy=%b c_load=%b want 1 1", busy, c_load);
        end
        for (int n = 0; n < 120; n++) begin
            if (c_load) begin
                checks++;
                if (cout !== 4'(n_load) || n != 13 * n_load) begin
                    errors++; $display("FAIL nom_load cout=%0d cyc=%0d want %0d %0d", cout, n, n_load, 13 * n_load);
                end
                if (n_load < 8) begin
                    acc = acc_tab[n_load];
                    bias = bias_tab[n_load];
                end
                n_load++;
            end
            if (mac_en) begin
                n_mac++;
                if (mac_clr) n_clr++;
                if (k_idx !== 8'(kexp) || mac_clr !== (kexp == 0)) bad_k++;
                kexp = (kexp == 8) ? 0 : kexp + 1;
            end
            if (out_valid) begin
                checks++;
                if (n_val > 7 || out_data !== exp_tab[n_val] || n != 13 * n_val + 12) begin
                    errors++; $display("FAIL nom_out ch=%0d data=%0d cyc=%0d want %0d %0d",
                                       n_val, out_data, n, exp_tab[n_val & 7], 13 * n_val + 12);
                end
                n_val++;
            end
            if (done) begin
                n_done++;
                done_at = n;
            end
            @(negedge clk);
        end
        checks++;
        if (n_load != 8 || n_mac != 72 || n_clr != 8 || bad_k != 0) begin
            errors++; $display("FAIL nom_counts load=%0d mac=%0d clr=%0d badk=%0d want 8 72 8 0",
                               n_load, n_mac, n_clr, bad_k);
        end
        checks++;
        if (n_done != 1 || done_at != 104 || n_val != 8) begin
            errors++; $display("FAIL nom_done count=%0d at=%0d vals=%0d want 1 104 8", n_done, done_at, n_val);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL nom_idle busy=%b want 0", busy);
        end
    endtask

    task automatic test_backpressure();
        logic signed [7:0] d;
        logic [3:0] c;
        bit seen = 0;
        acc = -20'sd5; bias = 8'sd10;
        out_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 50 && !seen; i++) begin
            if (out_valid) seen = 1; else @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL bp_wait out_valid=%b want 1 within 50 cycles", out_valid);
        end
        d = out_data; c = cout;
        checks++;
        if (d !== 8'sd5 || c !== 4'd0) begin
            errors++; $display("FAIL bp_data data=%0d cout=%0d want 5 0", d, c);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== d || c_load !== 1'b0 || cout !== c) begin
                errors++; $display("FAIL bp_hold cyc=%0d valid=%b data=%0d c_load=%b cout=%0d want 1 %0d 0 %0d",
                                   i, out_valid, out_data, c_load, cout, d, c);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || c_load !== 1'b1 || cout !== c + 4'd1) begin
            errors++; $display("FAIL bp_release valid=%b c_load=%b cout=%0d want 0 1 %0d",
                               out_valid, c_load, cout, c + 4'd1);
        end
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (done) seen = 1; else @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL bp_done done=%b want 1 within 200 cycles", done);
        end
        @(negedge clk);
    endtask

    task automatic test_start_busy();
        int n_done = 0, n_load = 0, load_after = 0;
        out_ready = 1'b1;
        pulse_start();
        for (int n = 0; n < 130; n++) begin
            start = 1'b0;
            if (c_load) begin
                n_load++;
                if (n_done > 0) load_after++;
                if (cout == 4'd2) start = 1'b1;
            end
            // The final handshake edge also samples this start; it must be dropped.
            if (out_valid && cout == 4'd7) start = 1'b1;
            if (done) n_done++;
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (n_done != 1 || n_load != 8 || load_after != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL start_busy done=%0d loads=%0d after=%0d busy=%b want 1 8 0 0",
                               n_done, n_load, load_after, busy);
        end
    endtask

    task automatic test_back_to_back();
        bit seen = 0;
        out_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 200 && !seen; i++) begin
            if (done) seen = 1; else @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL b2b_done done=%b want 1 within 200 cycles", done);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (c_load !== 1'b1 || cout !== 4'd0 || busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL b2b_restart c_load=%b cout=%0d busy=%b done=%b want 1 0 1 0",
                               c_load, cout, busy, done);
        end
        seen = 0;
        for (int i = 0; i < 80 && !seen; i++) begin
            if (mac_en && cout == 4'd3 && k_idx == 8'd4) seen = 1; else @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL b2b_mac3 cout=%0d mac_en=%b want 3 1 within 80 cycles", cout, mac_en);
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] v;
        int bad = 0;
        #2 rst = 1'b0;
        #1;
        v = {busy, done, c_load, cout, mac_en, mac_clr, k_idx, out_valid, out_data[0]};
        checks++;
        if (v !== 24'h0 || out_data !== 8'sd0) begin
            errors++; $display("FAIL rst_mid outputs=%h data=%0d want 0", v, out_data);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0 || c_load !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL rst_after bad_cycles=%0d want 0", bad);
        end
    endtask

    task automatic test_boundary();
        // {c_load, mac_en, mac_clr, out_valid, done} per cycle after start is accepted.
        logic [4:0] exp_v [12] = '{5'b10000, 5'b01100, 5'b00000, 5'b00010,
                                   5'b10000, 5'b01100, 5'b00000, 5'b00010,
                                   5'b00001, 5'b00000, 5'b00000, 5'b00000};
        logic [4:0] v;
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        for (int n = 0; n < 12; n++) begin
            v = {c_load_b, mac_en_b, mac_clr_b, out_valid_b, done_b};
            checks++;
            if (v !== exp_v[n]) begin
                errors++; $display("FAIL bnd_seq cyc=%0d got=%b want=%b", n, v, exp_v[n]);
            end
            if (n == 4 || n == 7) begin
                checks++;
                if (cout_b !== 4'd1 || (n == 7 && out_data_b !== 8'sd40)) begin
                    errors++; $display("FAIL bnd_ch1 cyc=%0d cout=%0d data=%0d want 1 40", n, cout_b, out_data_b);
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_start_busy();
        test_back_to_back();
        test_reset_mid();
        test_boundary();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_oc_sched.md
Name: conv_oc_sched

Overview:
- Per-output-pixel scheduler for the conv layer.
- On each start pulse it walks output channels 0..OC in order. For each channel it:
  - pulses c_load to the bias ROM with the channel index;
  - drives NK MAC enable cycles;
  - waits for the MAC pipeline to drain;
  - adds the bias to the accumulator and saturates to int8;
  - hands the result downstream with a valid/ready handshake.
- Sits between the layer-level pixel sequencer (start/done) and the bias ROM, MAC array and output buffer.

Parameters:
- OC, 7, out_channels - 1; cout counts 0..OC.
- NK, 9, MAC taps per output channel (kernel_h*kernel_w*in_channels); must be >= 1.
- MAC_LAT, 2, cycles from the last mac_en until acc is valid; must be >= 1.
- ACC_W, 20, accumulator width, signed.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle pulse that begins a pixel; sampled only in IDLE.
- busy, output, 1, high from the cycle after start is accepted until done.
- done, output, 1, one-cycle pulse after the last channel handshake.
- c_load, output, 1, bias ROM load strobe.
- cout, output, 4, current output channel index (ROM address).
- bias, input, 8, signed bias from the ROM; valid the cycle after c_load.
- mac_en, output, 1, MAC accumulate enable.
- mac_clr, output, 1, high with mac_en on the first tap; MAC loads instead of accumulating.
- k_idx, output, 8, current tap index 0..NK-1 (weight/activation address).
- acc, input, ACC_W, signed MAC accumulator result.
- out_valid, output, 1, result valid.
- out_ready, input, 1, downstream accept.
- out_data, output, 8, signed saturated result.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; every output 0, including cout, k_idx and out_data. Reset mid-operation abandons the pixel; no done pulse is issued.
- IDLE:
  - start=1 -> LOAD with cout=0. busy rises on that same transition edge.
  - start pulses while busy are ignored and not queued.
- LOAD, 1 cycle:
  - c_load=1 and cout holds the current channel.
  - -> MAC with k_idx=0.
- MAC, exactly NK cycles:
  - mac_en=1; k_idx goes 0..NK-1.
  - mac_clr=1 only when k_idx=0.
  - After k_idx=NK-1 -> DRAIN and clear the drain counter.
- DRAIN, exactly MAC_LAT cycles: all strobes low. On the last cycle, register the output:
  - sum = sign_ext(acc, ACC_W+1) + sign_ext(bias, ACC_W+1);
  - out_data = 127 if sum > 127, -128 if sum < -128, else sum[7:0];
  - out_valid <= 1; -> OUT.
- OUT:
  - out_valid and out_data are held stable until out_valid && out_ready.
  - On the handshake, out_valid drops on the next edge.
  - If cout == OC: done=1 for one cycle, busy=0, cout=0, -> IDLE.
  - Otherwise cout <= cout+1 and -> LOAD.
- bias is not re-sampled after LOAD; the ROM output stays stable because c_load is low.
- Per-channel latency with out_ready held high: 1 + NK + MAC_LAT + 1 cycles.
- Per-pixel latency with out_ready held high: (OC+1) times that.
- cout never exceeds OC; there is no wrap past OC.

Optional Feature:
- RELU_EN defined: the clamp lower bound is 0. Negative sums produce out_data = 0; the upper clamp stays 127.
- RELU_EN undefined: signed saturation to [-128, 127] as above.

Test Plan:
- Reset/idle: rst low mid-MAC (cout=3) -> all outputs 0 immediately; after release, no done and busy=0 until the next start.
- Nominal, OC=7, NK=9, MAC_LAT=2, out_ready=1: single start -> 8 c_load pulses with cout 0..7, each followed by 9 mac_en cycles (mac_clr on the first), out_valid every 13 cycles, done exactly once, 104 cycles after start.
- Arithmetic: acc=100, bias=20 -> out_data=120. acc=200, bias=5 -> 127. acc=-300, bias=-1 -> -128 (or 0 with RELU_EN). acc=-5, bias=10 -> 5.
- Backpressure: out_ready=0 for 5 cycles in OUT -> out_valid and out_data held constant, no c_load, cout unchanged; out_ready=1 -> next LOAD with cout+1.
- start while busy: pulse start at cout=2 -> ignored, with exactly one done for the pixel. start on the same edge as done/IDLE return is not accepted; start one cycle later begins a new pixel at cout=0.
- Boundary parameters NK=1, MAC_LAT=1: mac_en and mac_clr high together for one cycle; per-channel period of 4 cycles.
